// File: rtl/regfile_burst_master_pkg.sv
// Shared encodings for the register-file burst master: active-low strobe values, FSM states, defaults.
// REGFILE_BM_CLEAR_EN adds the CLR state used by clear bursts.
package regfile_burst_master_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

`ifdef REGFILE_BM_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_CLR  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;
`endif

    // Burst length carries one extra bit so a full-depth burst (2**ADDR_W) is representable.
    function automatic int len_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/regfile_burst_master_if.sv
// Command, write-stream, read-stream and register-file signals of the burst master.
// REGFILE_BM_CLEAR_EN adds cmd_clr to the command group.
interface regfile_burst_master_if #(
    parameter int DATA_W = regfile_burst_master_pkg::DEF_DATA_W,
    parameter int ADDR_W = regfile_burst_master_pkg::DEF_ADDR_W
);
    import regfile_burst_master_pkg::*;

    localparam int LEN_W = len_w(ADDR_W);

    logic              cmd_req;
    logic              cmd_ack;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
`ifdef REGFILE_BM_CLEAR_EN
    logic              cmd_clr;
`endif

    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;

    logic              busy;

    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_d_in;
    logic              rf_we_;
    logic [DATA_W-1:0] rf_d_out;

`ifdef REGFILE_BM_CLEAR_EN
    modport master (
        input  cmd_req, cmd_rw, cmd_addr, cmd_len, cmd_clr,
        input  wr_valid, wr_data, rd_ready, rf_d_out,
        output cmd_ack, wr_ready, rd_valid, rd_data, busy,
        output rf_addr, rf_d_in, rf_we_
    );
    modport slave (
        output cmd_req, cmd_rw, cmd_addr, cmd_len, cmd_clr,
        output wr_valid, wr_data, rd_ready, rf_d_out,
        input  cmd_ack, wr_ready, rd_valid, rd_data, busy,
        input  rf_addr, rf_d_in, rf_we_
    );
`else
    modport master (
        input  cmd_req, cmd_rw, cmd_addr, cmd_len,
        input  wr_valid, wr_data, rd_ready, rf_d_out,
        output cmd_ack, wr_ready, rd_valid, rd_data, busy,
        output rf_addr, rf_d_in, rf_we_
    );
    modport slave (
        output cmd_req, cmd_rw, cmd_addr, cmd_len,
        output wr_valid, wr_data, rd_ready, rf_d_out,
        input  cmd_ack, wr_ready, rd_valid, rd_data, busy,
        input  rf_addr, rf_d_in, rf_we_
    );
`endif

endinterface

// File: rtl/regfile_bm_addr_gen.sv
// Register-file address and remaining-word counter: load at command accept, step per word, wrap at depth.
// Address is registered; last flags the final word of the burst.
module regfile_bm_addr_gen #(
    parameter int ADDR_W = regfile_burst_master_pkg::DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W:0]   load_len,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            addr <= load_addr;
            // Longer requests are clamped so no word is touched twice in one burst.
            cnt  <= (load_len > DEPTH) ? DEPTH : load_len;
        end else if (step) begin
            addr <= addr + 1'b1;
            cnt  <= cnt - ONE;
        end
    end

    assign last = (cnt == ONE);

endmodule

// File: rtl/regfile_burst_master.sv
// Burst read/write master for the single-port register file; writes 1 word/cycle, first read word 2 cycles after accept.
// wr_valid stalls writes, rd_ready stalls the one-entry read register; optional clear bursts under REGFILE_BM_CLEAR_EN.
module regfile_burst_master #(
    parameter int DATA_W = regfile_burst_master_pkg::DEF_DATA_W,
    parameter int ADDR_W = regfile_burst_master_pkg::DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset_,
    regfile_burst_master_if.master bus
);
    import regfile_burst_master_pkg::*;

    localparam int LEN_W = len_w(ADDR_W);

    state_t              state;
    state_t              state_nxt;

    logic                accept;
    logic                ag_load;
    logic                ag_step;
    logic                ag_last;
    logic [ADDR_W-1:0]   ag_addr;
    logic [LEN_W-1:0]    ag_len;

    logic                rd_load;
    logic                cmd_ack_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;

    logic                wr_ready_c;
    logic                we_c;
    logic [DATA_W-1:0]   d_in_c;
    logic                clr_cmd;

    assign ag_len = bus.cmd_len;

`ifdef REGFILE_BM_CLEAR_EN
    assign clr_cmd = bus.cmd_clr;
`else
    assign clr_cmd = 1'b0;
`endif

    regfile_bm_addr_gen #(
        .ADDR_W    (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset_    (reset_),
        .load      (ag_load),
        .load_addr (bus.cmd_addr),
        .load_len  (ag_len),
        .step      (ag_step),
        .addr      (ag_addr),
        .last      (ag_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        ag_load    = 1'b0;
        ag_step    = 1'b0;
        rd_load    = 1'b0;
        wr_ready_c = 1'b0;
        we_c       = DISABLE_;
        d_in_c     = '0;

        case (state)
            ST_IDLE: begin
                // cmd_ack_q blocks a second accept while the requester still holds the acked command.
                if (bus.cmd_req && !rd_valid_q && !cmd_ack_q) begin
                    accept  = 1'b1;
                    ag_load = 1'b1;
                    if (bus.cmd_len != '0) begin
                        if (clr_cmd) begin
`ifdef REGFILE_BM_CLEAR_EN
                            state_nxt = ST_CLR;
`endif
                        end else if (bus.cmd_rw) begin
                            state_nxt = ST_WR;
                        end else begin
                            state_nxt = ST_RD;
                        end
                    end
                end
            end

            ST_WR: begin
                wr_ready_c = 1'b1;
                d_in_c     = bus.wr_data;
                we_c       = bus.wr_valid ? ENABLE_ : DISABLE_;
                if (bus.wr_valid) begin
                    ag_step = 1'b1;
                    if (ag_last) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end

            ST_RD: begin
                if (!rd_valid_q || bus.rd_ready) begin
                    rd_load = 1'b1;
                    ag_step = 1'b1;
                    if (ag_last) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end

`ifdef REGFILE_BM_CLEAR_EN
            ST_CLR: begin
                we_c    = ENABLE_;
                ag_step = 1'b1;
                if (ag_last) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            cmd_ack_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            cmd_ack_q <= accept;
            if (rd_load) begin
                rd_data_q  <= bus.rf_d_out;
                rd_valid_q <= 1'b1;
            end else if (rd_valid_q && bus.rd_ready) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign bus.cmd_ack  = cmd_ack_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = (state != ST_IDLE) | rd_valid_q;
    assign bus.rf_addr  = ag_addr;
    assign bus.rf_d_in  = d_in_c;

    // The word presented during a reset cycle must not land in the register file.
    assign bus.wr_ready = wr_ready_c & reset_;
    assign bus.rf_we_   = we_c | ~reset_;

endmodule

// File: tb/tb_regfile_burst_master.sv
// Directed bench for regfile_burst_master with a behavioural register file on the rf side.
module tb_regfile_burst_master;

    logic clk;
    logic reset_;

    int n_assert;
    int n_fail;

    logic [31:0] mem [0:31];

    regfile_burst_master_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_burst_master #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port register file: synchronous write, combinational read.
    always @(posedge clk) begin
        if (bus.rf_we_ == 1'b0) begin
            mem[bus.rf_addr] <= bus.rf_d_in;
        end
    end
    assign bus.rf_d_out = mem[bus.rf_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_words [0:3];
        logic [19:0] pat;
        int          n_cons;
        int          n_xfer;

        n_assert = 0;
        n_fail   = 0;
        reset_   = 1'b0;
        bus.cmd_req  = 1'b0;
        bus.cmd_rw   = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_len  = '0;
`ifdef REGFILE_BM_CLEAR_EN
        bus.cmd_clr  = 1'b0;
`endif
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_cmd_ack",  64'(bus.cmd_ack),  64'd0);
        chk("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_rd_data",  64'(bus.rd_data),  64'd0);
        chk("rst_busy",     64'(bus.busy),     64'd0);
        chk("rst_rf_addr",  64'(bus.rf_addr),  64'd0);
        chk("rst_rf_we_",   64'(bus.rf_we_),   64'd1);
        chk("rst_rf_d_in",  64'(bus.rf_d_in),  64'd0);
        reset_ = 1'b1;

        // Write burst addr 4, len 3: A, B, C
        step();
        bus.cmd_req = 1'b1; bus.cmd_rw = 1'b1; bus.cmd_addr = 5'd4; bus.cmd_len = 6'd3;
        bus.wr_valid = 1'b1; bus.wr_data = 32'hA;
        step();
        chk("wr1_ack",      64'(bus.cmd_ack),  64'd1);
        chk("wr1_wr_ready", 64'(bus.wr_ready), 64'd1);
        chk("wr1_addr0",    64'(bus.rf_addr),  64'd4);
        chk("wr1_we0",      64'(bus.rf_we_),   64'd0);
        chk("wr1_din0",     64'(bus.rf_d_in),  64'hA);
        chk("wr1_busy",     64'(bus.busy),     64'd1);
        bus.cmd_req = 1'b0;
        step();
        bus.wr_data = 32'hB;
        #1;
        chk("wr1_ack_pulse", 64'(bus.cmd_ack), 64'd0);
        chk("wr1_addr1",     64'(bus.rf_addr), 64'd5);
        chk("wr1_we1",       64'(bus.rf_we_),  64'd0);
        chk("wr1_din1",      64'(bus.rf_d_in), 64'hB);
        step();
        bus.wr_data = 32'hC;
        #1;
        chk("wr1_addr2", 64'(bus.rf_addr), 64'd6);
        chk("wr1_we2",   64'(bus.rf_we_),  64'd0);
        step();
        bus.wr_valid = 1'b0;
        #1;
        chk("wr1_done_we",    64'(bus.rf_we_),   64'd1);
        chk("wr1_done_ready", 64'(bus.wr_ready), 64'd0);
        chk("wr1_done_busy",  64'(bus.busy),     64'd0);
        chk("wr1_mem4", 64'(mem[4]), 64'hA);
        chk("wr1_mem5", 64'(mem[5]), 64'hB);
        chk("wr1_mem6", 64'(mem[6]), 64'hC);

        // Read burst addr 4, len 3 with rd_ready high: valid from T+2, one word per cycle
        bus.cmd_req = 1'b1; bus.cmd_rw = 1'b0; bus.cmd_addr = 5'd4; bus.cmd_len = 6'd3;
        bus.rd_ready = 1'b1;
        step();
        chk("rd1_ack",    64'(bus.cmd_ack),  64'd1);
        chk("rd1_t1_vld", 64'(bus.rd_valid), 64'd0);
        chk("rd1_t1_we",  64'(bus.rf_we_),   64'd1);
        bus.cmd_req = 1'b0;
        step();
        chk("rd1_vld0",  64'(bus.rd_valid), 64'd1);
        chk("rd1_data0", 64'(bus.rd_data),  64'hA);
        step();
        chk("rd1_vld1",  64'(bus.rd_valid), 64'd1);
        chk("rd1_data1", 64'(bus.rd_data),  64'hB);
        step();
        chk("rd1_vld2",  64'(bus.rd_valid), 64'd1);
        chk("rd1_data2", 64'(bus.rd_data),  64'hC);
        chk("rd1_busy_pending", 64'(bus.busy), 64'd1);
        step();
        chk("rd1_drained_vld",  64'(bus.rd_valid), 64'd0);
        chk("rd1_drained_busy", 64'(bus.busy),     64'd0);

        // Write burst across the wrap point: addr 30, 31, 0, 1
        bus.rd_ready = 1'b0;
        bus.cmd_req = 1'b1; bus.cmd_rw = 1'b1; bus.cmd_addr = 5'd30; bus.cmd_len = 6'd4;
        bus.wr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            bus.cmd_req = 1'b0;
            bus.wr_data = 32'h30 + 32'(k);
            #1;
            chk("wrap_wr_addr", 64'(bus.rf_addr), 64'((30 + k) % 32));
            chk("wrap_wr_we",   64'(bus.rf_we_),  64'd0);
        end
        step();
        bus.wr_valid = 1'b0;
        #1;
        chk("wrap_wr_busy", 64'(bus.busy), 64'd0);

        // Read the wrapped range with rd_ready stalls
        exp_words[0] = 32'h30; exp_words[1] = 32'h31;
        exp_words[2] = 32'h32; exp_words[3] = 32'h33;
        pat    = 20'b1111_1111_1110_0101_1001;
        n_cons = 0;
        bus.cmd_req = 1'b1; bus.cmd_rw = 1'b0; bus.cmd_addr = 5'd30; bus.cmd_len = 6'd4;
        for (int k = 0; k < 20; k++) begin
            step();
            bus.cmd_req  = 1'b0;
            bus.rd_ready = pat[k];
            #1;
            if (bus.rd_valid) begin
                if (n_cons < 4) begin
                    chk("wrap_rd_data", 64'(bus.rd_data), 64'(exp_words[n_cons]));
                end else begin
                    chk("wrap_rd_extra", 64'(bus.rd_valid), 64'd0);
                end
                if (bus.rd_ready) n_cons++;
            end
        end
        chk("wrap_rd_count", 64'(n_cons), 64'd4);
        chk("wrap_rd_busy",  64'(bus.busy), 64'd0);
        bus.rd_ready = 1'b0;

        // Zero-length command: one ack, no transfer; cmd_req held through the ack cycle
        bus.cmd_req = 1'b1; bus.cmd_rw = 1'b1; bus.cmd_addr = 5'd3; bus.cmd_len = 6'd0;
        bus.wr_valid = 1'b1;
        step();
        chk("len0_ack",      64'(bus.cmd_ack),  64'd1);
        chk("len0_we",       64'(bus.rf_we_),   64'd1);
        chk("len0_wr_ready", 64'(bus.wr_ready), 64'd0);
        chk("len0_busy",     64'(bus.busy),     64'd0);
        step();
        bus.cmd_req = 1'b0;
        #1;
        chk("len0_single_ack", 64'(bus.cmd_ack), 64'd0);
        chk("len0_we_after",   64'(bus.rf_we_),  64'd1);
        step();
        chk("len0_ack_after", 64'(bus.cmd_ack),  64'd0);
        chk("len0_no_rd",     64'(bus.rd_valid), 64'd0);

        // Oversized length 63 from addr 7: clamped to 32 writes, word i lands at (7+i) mod 32
        bus.cmd_req = 1'b1; bus.cmd_rw = 1'b1; bus.cmd_addr = 5'd7; bus.cmd_len = 6'd63;
        n_xfer = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            bus.cmd_req = 1'b0;
            bus.wr_data = 32'h100 + 32'(n_xfer);
            #1;
            if (bus.rf_we_ == 1'b0) n_xfer++;
        end
        bus.wr_valid = 1'b0;
        chk("len63_xfers", 64'(n_xfer), 64'd32);
        chk("len63_busy",  64'(bus.busy), 64'd0);
        chk("len63_mem7",  64'(mem[7]), 64'h100);
        chk("len63_mem6",  64'(mem[6]), 64'h11F);
        chk("len63_mem0",  64'(mem[0]), 64'h119);

        // New command held while a read word is stalled: no ack until rd_valid clears
        bus.cmd_req = 1'b1; bus.cmd_rw = 1'b0; bus.cmd_addr = 5'd0; bus.cmd_len = 6'd2;
        step();
        chk("blk_rd_ack", 64'(bus.cmd_ack), 64'd1);
        bus.cmd_req = 1'b0;
        step();
        chk("blk_vld", 64'(bus.rd_valid), 64'd1);
        bus.cmd_req = 1'b1; bus.cmd_rw = 1'b1; bus.cmd_addr = 5'd9; bus.cmd_len = 6'd4;
        step();
        chk("blk_no_ack0", 64'(bus.cmd_ack), 64'd0);
        chk("blk_hold0",   64'(bus.rd_data), 64'h119);
        step();
        chk("blk_no_ack1", 64'(bus.cmd_ack), 64'd0);
        chk("blk_hold1",   64'(bus.rd_data), 64'h119);
        bus.rd_ready = 1'b1;
        step();
        chk("blk_no_ack2", 64'(bus.cmd_ack),  64'd0);
        chk("blk_data1",   64'(bus.rd_data),  64'h11A);
        chk("blk_vld1",    64'(bus.rd_valid), 64'd1);
        step();
        chk("blk_no_ack3", 64'(bus.cmd_ack),  64'd0);
        chk("blk_drained", 64'(bus.rd_valid), 64'd0);
        step();
        chk("blk_ack", 64'(bus.cmd_ack), 64'd1);
        chk("blk_wr_addr", 64'(bus.rf_addr), 64'd9);
        bus.cmd_req  = 1'b0;
        bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h55;

        // Reset in the middle of the write burst
        step();
        reset_ = 1'b0;
        bus.wr_data = 32'h66;
        step();
        reset_ = 1'b1;
        bus.wr_data = 32'h77;
        #1;
        chk("mid_rst_we",       64'(bus.rf_we_),   64'd1);
        chk("mid_rst_wr_ready", 64'(bus.wr_ready), 64'd0);
        chk("mid_rst_busy",     64'(bus.busy),     64'd0);
        chk("mid_rst_ack",      64'(bus.cmd_ack),  64'd0);
        step();
        chk("mid_rst_we_later", 64'(bus.rf_we_), 64'd1);
        bus.wr_valid = 1'b0;
        step();
        chk("mid_rst_mem9",  64'(mem[9]),  64'h55);
        chk("mid_rst_mem11", 64'(mem[11]), 64'h104);
        chk("mid_rst_mem12", 64'(mem[12]), 64'h105);

`ifdef REGFILE_BM_CLEAR_EN
        // Clear burst over the whole file, then read it back
        bus.cmd_req = 1'b1; bus.cmd_clr = 1'b1; bus.cmd_rw = 1'b0;
        bus.cmd_addr = 5'd0; bus.cmd_len = 6'd32;
        n_xfer = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            bus.cmd_req = 1'b0;
            bus.cmd_clr = 1'b0;
            #1;
            if (bus.rf_we_ == 1'b0) begin
                n_xfer++;
                chk("clr_din", 64'(bus.rf_d_in), 64'd0);
            end
        end
        chk("clr_cycles", 64'(n_xfer), 64'd32);
        bus.cmd_req = 1'b1; bus.cmd_rw = 1'b0; bus.cmd_addr = 5'd0; bus.cmd_len = 6'd32;
        bus.rd_ready = 1'b1;
        n_cons = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            bus.cmd_req = 1'b0;
            #1;
            if (bus.rd_valid) begin
                n_cons++;
                chk("clr_rd_zero", 64'(bus.rd_data), 64'd0);
            end
        end
        chk("clr_rd_count", 64'(n_cons), 64'd32);
        bus.rd_ready = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
